// File: rtl/mcu_prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The stream source and the memory sit on the master side; the loader is the slave.
interface mcu_prog_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/mcu_prog_loader.sv
// Loads a framed program image (LEN, data bytes, CSUM) into MCU program memory,
// holding the MCU in reset until the checksum matches.
module mcu_prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rs,
    mcu_prog_loader_if.slave       bus,
    input  logic                   reload,
    output logic                   mcu_rs,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_done;
    logic              r_err;

    state_t            w_state_next;
    logic [7:0]        w_cnt_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [7:0]        w_sum_next;
    logic              w_mem_we_next;
    logic [ADDR_W-1:0] w_mem_addr_next;
    logic [7:0]        w_mem_wdata_next;
    logic              w_done_next;
    logic              w_err_next;
    logic              w_in_ready;
    logic              w_accept;

    // Ready depends on state only, so there is no path from in_valid to in_ready.
    assign w_in_ready = (r_state != ST_RUN);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_addr_next      = r_addr;
        w_sum_next       = r_sum;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_done_next      = r_done;
        w_err_next       = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = bus.in_data;
                    w_addr_next  = BASE;
                    w_sum_next   = 8'h00;
                    w_done_next  = 1'b0;
                    w_err_next   = 1'b0;
                    w_state_next = (bus.in_data != 8'h00) ? ST_DATA : ST_CHECK;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = r_addr;
                    w_mem_wdata_next = bus.in_data;
                    w_addr_next      = r_addr + 1'b1;
                    w_sum_next       = r_sum + bus.in_data;
                    w_cnt_next       = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    if (bus.in_data == r_sum) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    w_done_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'h00;
            r_addr      <= BASE;
            r_sum       <= 8'h00;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE;
            r_mem_wdata <= 8'h00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_addr      <= w_addr_next;
            r_sum       <= w_sum_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign mcu_rs        = (r_state != ST_RUN);
    assign done          = r_done;
    assign err           = r_err;
endmodule
